regfile_write_arbiter: RTL and testbench
========================================

REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default 32, register data width.
REQ-002 SHALL have parameter NREG, default 32, number of architectural registers; register address width is 5.
REQ-003 SHALL have parameter STARVE_MAX, default 3, maximum consecutive denied cycles for the ALU requester.
REQ-004 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n, input, 1, reset: asynchronous assertion, active-low.
REQ-006 SHALL have port alu_valid, input, 1, ALU write-back request.
REQ-007 SHALL have port alu_reg, input, 5, ALU destination register.
REQ-008 SHALL have port alu_data, input, DATA_W, ALU write-back data.
REQ-009 SHALL have port alu_ready, output, 1, ALU request accepted this cycle.
REQ-010 SHALL have ports mem_valid / mem_reg / mem_data / mem_ready with the same directions and widths as the ALU ports, for load write-back.
REQ-011 SHALL have port rf_we, output, 1, register file write enable.
REQ-012 SHALL have port rf_waddr, output, 5, register file write address.
REQ-013 SHALL have port rf_wdata, output, DATA_W, register file write data.
REQ-014 SHALL have port init_done, output, 1, high once the clearing sweep completes.

Function
REQ-015 SHALL implement two states: INIT and RUN.
REQ-016 INIT SHALL drive rf_we=1, rf_waddr=sweep counter, and rf_wdata=0 for NREG consecutive cycles, with addresses 0..NREG-1 in order.
REQ-017 After the cycle that writes address NREG-1, the block SHALL enter RUN and set init_done=1; init_done SHALL stay 1 until reset.
REQ-018 In INIT, alu_ready and mem_ready SHALL be 0.
REQ-019 A transfer SHALL occur on a requester when valid and ready are both 1 at a rising clk edge.
REQ-020 In RUN, at most one of alu_ready and mem_ready SHALL be 1 in any cycle.
REQ-021 alu_ready and mem_ready SHALL be combinational from the valids and the starvation counter; no dependence on ready-to-valid.
REQ-022 The default grant SHALL be: mem wins if mem_valid=1; otherwise alu wins if alu_valid=1.
REQ-023 The starvation counter SHALL increment, saturating at STARVE_MAX, in every RUN cycle with alu_valid=1 and alu_ready=0.
REQ-024 The starvation counter SHALL clear on an ALU transfer or when alu_valid=0.
REQ-025 When the starvation counter equals STARVE_MAX and alu_valid=1, alu SHALL be granted (alu_ready=1, mem_ready=0).
REQ-026 A transfer SHALL register {reg, data}; rf_we=1 with those values SHALL appear exactly one cycle later, giving a latency of 1.
REQ-027 A transfer to register 0 SHALL be accepted (ready=1), but the following cycle SHALL have rf_we=0.
REQ-028 In RUN cycles following no transfer, rf_we SHALL be 0 and rf_waddr/rf_wdata SHALL hold their last values.
REQ-029 Back-to-back transfers SHALL sustain one write per cycle with no bubble.
REQ-030 Requesters hold valid/reg/data stable until ready; the block does not check this, and its behaviour is undefined on violation.
REQ-031 When both requesters target the same register in the same cycle, the block SHALL perform both writes in grant order; the later write determines the final value.

Reset
REQ-032 rst_n=0 SHALL immediately force the following values: state=INIT, sweep counter=0, starvation counter=0, rf_we=0, rf_waddr=0, rf_wdata=0, init_done=0, alu_ready=0, mem_ready=0.
REQ-033 Reset asserted at any point, including mid-sweep or mid-transfer, SHALL discard pending writes; the sweep SHALL restart at address 0 on the first clk edge after release.

Verification
REQ-034 Release reset with both valids low: rf_we=1 for 32 cycles, addresses 0..31, data 0; then init_done=1 and rf_we=0.
REQ-035 In RUN, alu_valid=1, alu_reg=9, alu_data=0x1234: alu_ready=1 that cycle, and the next cycle shows rf_we=1, rf_waddr=9, rf_wdata=0x1234.
REQ-036 mem_valid and alu_valid held high continuously: the grant sequence shall be mem,mem,mem,alu,mem,mem,mem,alu, and each write appears one cycle after its grant.
REQ-037 mem_valid=1 with mem_reg=0 and mem_data=0xFFFF: mem_ready=1, and the next cycle shows rf_we=0.
REQ-038 Both requesters target reg 16 in the same cycle, with mem_data=5 and alu_data=7: writes occur as 5 then 7 on consecutive cycles.
REQ-039 Assert rst_n=0 at sweep address 12: outputs clear at once; after release, the sweep restarts at address 0 and runs 32 cycles.

Source files
------------

// File: rtl/regfile_write_arbiter.sv
// ============================================================================
// Module  : regfile_write_arbiter
// Brief   : Clears the register file after reset, then arbitrates ALU and
//           load write-back ports onto a single register-file write port.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_write_arbiter #(
  parameter int DATA_W     = 32,
  parameter int NREG       = 32,
  parameter int STARVE_MAX = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              alu_valid,
  input  logic [4:0]        alu_reg,
  input  logic [DATA_W-1:0] alu_data,
  output logic              alu_ready,
  input  logic              mem_valid,
  input  logic [4:0]        mem_reg,
  input  logic [DATA_W-1:0] mem_data,
  output logic              mem_ready,
  output logic              rf_we,
  output logic [4:0]        rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              init_done
);

  localparam int SW_W = $clog2(NREG + 1);
  localparam int ST_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  localparam logic [SW_W-1:0] SWEEP_END  = SW_W'(NREG);
  localparam logic [ST_W-1:0] STARVE_LIM = ST_W'(STARVE_MAX);

  logic [0:0]        state_q,     state_d;
  logic [SW_W-1:0]   sweep_q,     sweep_d;
  logic [ST_W-1:0]   starve_q,    starve_d;
  logic              rf_we_q,     rf_we_d;
  logic [4:0]        rf_waddr_q,  rf_waddr_d;
  logic [DATA_W-1:0] rf_wdata_q,  rf_wdata_d;
  logic              init_done_q, init_done_d;

  logic w_run;
  logic w_starve;

  assign w_run    = (state_q == ST_RUN);
  assign w_starve = alu_valid && (starve_q == STARVE_LIM);

  // Load write-back has priority unless the ALU has waited its limit.
  assign alu_ready = w_run && alu_valid && (!mem_valid || w_starve);
  assign mem_ready = w_run && mem_valid && !w_starve;

  always_comb begin
    state_d     = state_q;
    sweep_d     = sweep_q;
    starve_d    = starve_q;
    rf_we_d     = 1'b0;
    rf_waddr_d  = rf_waddr_q;
    rf_wdata_d  = rf_wdata_q;
    init_done_d = init_done_q;

    if (state_q == ST_INIT) begin
      // sweep_q is the next address to clear; reaching NREG means the last
      // clearing write is currently on the outputs.
      if (sweep_q == SWEEP_END) begin
        state_d     = ST_RUN;
        init_done_d = 1'b1;
      end else begin
        rf_we_d    = 1'b1;
        rf_waddr_d = 5'(sweep_q);
        rf_wdata_d = '0;
        sweep_d    = sweep_q + SW_W'(1);
      end
    end else begin
      if (alu_ready) begin
        if (alu_reg != 5'd0) begin
          rf_we_d    = 1'b1;
          rf_waddr_d = alu_reg;
          rf_wdata_d = alu_data;
        end
      end else if (mem_ready) begin
        if (mem_reg != 5'd0) begin
          rf_we_d    = 1'b1;
          rf_waddr_d = mem_reg;
          rf_wdata_d = mem_data;
        end
      end

      if (!alu_valid || alu_ready) begin
        starve_d = '0;
      end else if (starve_q != STARVE_LIM) begin
        starve_d = starve_q + ST_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_INIT;
      sweep_q     <= '0;
      starve_q    <= '0;
      rf_we_q     <= 1'b0;
      rf_waddr_q  <= '0;
      rf_wdata_q  <= '0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sweep_q     <= sweep_d;
      starve_q    <= starve_d;
      rf_we_q     <= rf_we_d;
      rf_waddr_q  <= rf_waddr_d;
      rf_wdata_q  <= rf_wdata_d;
      init_done_q <= init_done_d;
    end
  end

  assign rf_we     = rf_we_q;
  assign rf_waddr  = rf_waddr_q;
  assign rf_wdata  = rf_wdata_q;
  assign init_done = init_done_q;

endmodule

`default_nettype wire

// File: tb/tb_regfile_write_arbiter.sv
// ============================================================================
// Module  : tb_regfile_write_arbiter
// Brief   : Directed and randomized self-checking bench for the write arbiter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_regfile_write_arbiter;

  localparam int DATA_W     = 32;
  localparam int NREG       = 32;
  localparam int STARVE_MAX = 3;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              alu_valid = 1'b0;
  logic [4:0]        alu_reg = '0;
  logic [DATA_W-1:0] alu_data = '0;
  logic              alu_ready;
  logic              mem_valid = 1'b0;
  logic [4:0]        mem_reg = '0;
  logic [DATA_W-1:0] mem_data = '0;
  logic              mem_ready;
  logic              rf_we;
  logic [4:0]        rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic              init_done;

  regfile_write_arbiter #(
    .DATA_W    (DATA_W),
    .NREG      (NREG),
    .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .alu_valid(alu_valid),
    .alu_reg  (alu_reg),
    .alu_data (alu_data),
    .alu_ready(alu_ready),
    .mem_valid(mem_valid),
    .mem_reg  (mem_reg),
    .mem_data (mem_data),
    .mem_ready(mem_ready),
    .rf_we    (rf_we),
    .rf_waddr (rf_waddr),
    .rf_wdata (rf_wdata),
    .init_done(init_done)
  );

  always #5 clk = ~clk;

  int npass = 0;
  int nchk  = 0;
  int nfail = 0;

  // Reference state: how long the ALU has been refused, and what the
  // write port should show after the next edge.
  int                m_wait = 0;
  logic              e_we = 1'b0;
  logic [4:0]        e_addr = '0;
  logic [DATA_W-1:0] e_data = '0;
  logic              last_ga = 1'b0;
  logic              last_gm = 1'b0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nchk++;
    assert (got === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_cycle(input string tag);
    logic starve, ga, gm;
    #1;
    starve = alu_valid && (m_wait >= STARVE_MAX);
    ga     = alu_valid && (!mem_valid || starve);
    gm     = mem_valid && !ga;
    chk({tag, ".alu_ready"}, 64'(alu_ready), 64'(ga));
    chk({tag, ".mem_ready"}, 64'(mem_ready), 64'(gm));
    e_we = 1'b0;
    if (ga && alu_reg != 5'd0) begin
      e_we = 1'b1; e_addr = alu_reg; e_data = alu_data;
    end else if (gm && mem_reg != 5'd0) begin
      e_we = 1'b1; e_addr = mem_reg; e_data = mem_data;
    end
    if (alu_valid && !ga) m_wait = (m_wait >= STARVE_MAX) ? STARVE_MAX : m_wait + 1;
    else                  m_wait = 0;
    last_ga = ga;
    last_gm = gm;
    tick();
    chk({tag, ".rf_we"},    64'(rf_we),    64'(e_we));
    chk({tag, ".rf_waddr"}, 64'(rf_waddr), 64'(e_addr));
    chk({tag, ".rf_wdata"}, 64'(rf_wdata), 64'(e_data));
  endtask

  task automatic sweep_check(input string tag);
    for (int i = 0; i < NREG; i++) begin
      tick();
      chk({tag, ".we"},        64'(rf_we),     64'(1));
      chk({tag, ".addr"},      64'(rf_waddr),  64'(i));
      chk({tag, ".data"},      64'(rf_wdata),  64'(0));
      chk({tag, ".init_done"}, 64'(init_done), 64'(0));
      chk({tag, ".alu_ready"}, 64'(alu_ready), 64'(0));
      chk({tag, ".mem_ready"}, 64'(mem_ready), 64'(0));
    end
    tick();
    chk({tag, ".done_hi"}, 64'(init_done), 64'(1));
    chk({tag, ".we_lo"},   64'(rf_we),     64'(0));
    chk({tag, ".hold"},    64'(rf_waddr),  64'(NREG - 1));
    e_we = 1'b0; e_addr = 5'(NREG - 1); e_data = '0;
    m_wait = 0; last_ga = 1'b0; last_gm = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".we"},        64'(rf_we),     64'(0));
    chk({tag, ".addr"},      64'(rf_waddr),  64'(0));
    chk({tag, ".data"},      64'(rf_wdata),  64'(0));
    chk({tag, ".init_done"}, 64'(init_done), 64'(0));
    chk({tag, ".alu_ready"}, 64'(alu_ready), 64'(0));
    chk({tag, ".mem_ready"}, 64'(mem_ready), 64'(0));
  endtask

  initial begin
    logic [7:0] seq;

    // Reset values with requesters active
    alu_valid = 1'b1; mem_valid = 1'b1;
    tick(); tick();
    chk_reset_vals("reset");

    // Clearing sweep after release, both valids low
    alu_valid = 1'b0; mem_valid = 1'b0;
    rst_n = 1'b1;
    sweep_check("sweep");

    // Single ALU write to reg 9
    alu_valid = 1'b1; alu_reg = 5'd9; alu_data = 32'h1234;
    run_cycle("alu9");
    alu_valid = 1'b0;
    chk("alu9.addr_k", 64'(rf_waddr), 64'(9));
    chk("alu9.data_k", 64'(rf_wdata), 64'h1234);
    run_cycle("idle_hold");

    // Both requesters held high: mem,mem,mem,alu repeating
    seq = 8'b1000_1000;
    alu_valid = 1'b1; alu_reg = 5'd3; alu_data = 32'hA000;
    mem_valid = 1'b1; mem_reg = 5'd1; mem_data = 32'hB000;
    for (int k = 0; k < 8; k++) begin
      #1;
      chk("starve.seq_alu", 64'(alu_ready), 64'(seq[k]));
      chk("starve.seq_mem", 64'(mem_ready), 64'(!seq[k]));
      run_cycle("starve");
      if (last_ga) begin alu_reg = alu_reg + 5'd1; alu_data = alu_data + 32'd1; end
      if (last_gm) begin mem_reg = mem_reg + 5'd1; mem_data = mem_data + 32'd1; end
    end
    alu_valid = 1'b0; mem_valid = 1'b0;
    run_cycle("starve_end");

    // Load to reg 0 is accepted but not written
    mem_valid = 1'b1; mem_reg = 5'd0; mem_data = 32'hFFFF;
    run_cycle("mem_r0");
    mem_valid = 1'b0;
    chk("mem_r0.we_k", 64'(rf_we), 64'(0));

    // Same destination from both sides: mem first, ALU second
    mem_valid = 1'b1; mem_reg = 5'd16; mem_data = 32'd5;
    alu_valid = 1'b1; alu_reg = 5'd16; alu_data = 32'd7;
    run_cycle("same16.a");
    mem_valid = 1'b0;
    chk("same16.first", 64'(rf_wdata), 64'(5));
    run_cycle("same16.b");
    alu_valid = 1'b0;
    chk("same16.second", 64'(rf_wdata), 64'(7));
    chk("same16.we2", 64'(rf_we), 64'(1));
    run_cycle("same16.c");

    // Random traffic obeying hold-until-ready
    last_ga = 1'b0; last_gm = 1'b0;
    for (int n = 0; n < 400; n++) begin
      if (!alu_valid || last_ga) begin
        alu_valid = ($urandom_range(0, 9) < 7);
        alu_reg   = 5'($urandom_range(0, 31));
        alu_data  = $urandom;
      end
      if (!mem_valid || last_gm) begin
        mem_valid = ($urandom_range(0, 9) < 6);
        mem_reg   = 5'($urandom_range(0, 31));
        mem_data  = $urandom;
      end
      run_cycle("rand");
    end
    alu_valid = 1'b0; mem_valid = 1'b0;

    // Reset in the middle of the sweep
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    for (int i = 0; i <= 12; i++) tick();
    chk("midrst.at12", 64'(rf_waddr), 64'(12));
    rst_n = 1'b0;
    #1;
    chk_reset_vals("midrst");
    #2;
    alu_valid = 1'b1; alu_reg = 5'd4; alu_data = 32'h55;
    mem_valid = 1'b1; mem_reg = 5'd5; mem_data = 32'h66;
    rst_n = 1'b1;
    sweep_check("resweep");
    alu_valid = 1'b0; mem_valid = 1'b0;
    run_cycle("post_resweep");

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule

`default_nettype wire
